// File: rtl/lbp_pkg.sv
// Shared constants, FSM encoding and the border-address test for the LBP host responder.
package lbp_pkg;
   localparam int AW    = 14;
   localparam int DW    = 8;
   localparam int IMG_W = 128;
   localparam int CW    = 32;
   localparam int CB    = $clog2(IMG_W);
   localparam int DEPTH = IMG_W * IMG_W;

   localparam logic [CB-1:0] EDGE_LO = '0;
   localparam logic [CB-1:0] EDGE_HI = CB'(IMG_W - 1);

   typedef enum logic [1:0] {LOAD, SERVE, DONE} state_t;

   // Column lives in the low CB bits, row in the rest.
   function automatic logic is_border(input logic [AW-1:0] addr);
      logic [CB-1:0]    col;
      logic [AW-CB-1:0] row;
      col = addr[CB-1:0];
      row = addr[AW-1:CB];
      return (col == EDGE_LO) || (col == EDGE_HI) || (row == EDGE_LO) || (row == EDGE_HI);
   endfunction
endpackage

// File: rtl/lbp_host_responder_if.sv
// Pixel protocol between the LBP engine (master) and the host responder (slave).
interface lbp_host_responder_if;
   import lbp_pkg::*;

   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic          gray_ready;
   logic [DW-1:0] gray_data;
   logic          lbp_valid;
   logic [AW-1:0] lbp_addr;
   logic [DW-1:0] lbp_data;
   logic          finish;

   modport master (
      output gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
      input  gray_ready, gray_data
   );

   modport slave (
      input  gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish,
      output gray_ready, gray_data
   );
endinterface

// File: rtl/lbp_byte_ram.sv
// Byte-wide RAM: one synchronous write port, one asynchronous read port, one registered read port.
module lbp_byte_ram
   import lbp_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] araddr,
   output logic [DW-1:0] adata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign adata = mem[araddr];

   // Only the output register is reset; the array keeps its contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rdata <= '0;
      else       rdata <= mem[raddr];
   end
endmodule

// File: rtl/lbp_host_responder.sv
// Host-side responder: serves the image to the LBP engine, captures results, flags border writes, counts cycles.
module lbp_host_responder
   import lbp_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load_valid,
   input  logic [AW-1:0]         load_addr,
   input  logic [DW-1:0]         load_data,
   input  logic                  load_done,
   lbp_host_responder_if.slave   eng,
   input  logic [AW-1:0]         rd_addr,
   output logic [DW-1:0]         rd_data,
   output logic                  done,
   output logic                  border_err,
   output logic [CW-1:0]         cycles
);
   state_t        state_reg;
   logic          gray_ready_reg;
   logic          done_reg;
   logic          border_err_reg;
   logic [CW-1:0] cycles_reg;
   logic [DW-1:0] img_q;
   logic [DW-1:0] img_rdata_unused;
   logic [DW-1:0] res_adata_unused;
   logic          img_we;
   logic          res_we;

   assign img_we = (state_reg == LOAD) && load_valid;
   assign res_we = (state_reg == SERVE) && eng.lbp_valid;

   lbp_byte_ram u_img_ram (
      .clk    (clk),
      .reset  (reset),
      .we     (img_we),
      .waddr  (load_addr),
      .wdata  (load_data),
      .araddr (eng.gray_addr),
      .adata  (img_q),
      .raddr  (rd_addr),
      .rdata  (img_rdata_unused)
   );

   lbp_byte_ram u_res_ram (
      .clk    (clk),
      .reset  (reset),
      .we     (res_we),
      .waddr  (eng.lbp_addr),
      .wdata  (eng.lbp_data),
      .araddr (rd_addr),
      .adata  (res_adata_unused),
      .raddr  (rd_addr),
      .rdata  (rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= LOAD;
         gray_ready_reg <= 1'b0;
         done_reg       <= 1'b0;
         border_err_reg <= 1'b0;
         cycles_reg     <= '0;
      end else begin
         case (state_reg)
            LOAD: begin
               if (load_done) begin
                  state_reg      <= SERVE;
                  gray_ready_reg <= 1'b1;
               end
            end
            SERVE: begin
               if (cycles_reg != '1) cycles_reg <= cycles_reg + CW'(1);
               if (eng.lbp_valid && is_border(eng.lbp_addr)) border_err_reg <= 1'b1;
               // The finishing cycle still counts and still writes.
               if (eng.finish) begin
                  state_reg      <= DONE;
                  gray_ready_reg <= 1'b0;
                  done_reg       <= 1'b1;
               end
            end
            default: begin
               state_reg <= DONE;
            end
         endcase
      end
   end

   // Same-cycle read: the engine samples on the edge that moves gray_addr.
   assign eng.gray_data  = (gray_ready_reg && eng.gray_req) ? img_q : '0;
   assign eng.gray_ready = gray_ready_reg;
   assign done           = done_reg;
   assign border_err     = border_err_reg;
   assign cycles         = cycles_reg;
endmodule

// File: tb/tb_lbp_host_responder.sv
// Directed bench for lbp_host_responder: load, serve, capture, border flag, reset behaviour, mini engine run.
module tb_lbp_host_responder;
   import lbp_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_valid;
   logic [AW-1:0] load_addr;
   logic [DW-1:0] load_data;
   logic          load_done;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          done;
   logic          border_err;
   logic [CW-1:0] cycles;

   lbp_host_responder_if eng_if ();

   lbp_host_responder dut (
      .clk        (clk),
      .reset      (reset),
      .load_valid (load_valid),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .load_done  (load_done),
      .eng        (eng_if),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .done       (done),
      .border_err (border_err),
      .cycles     (cycles)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int tot_cnt  = 0;
   int exp_cycles = 0;
   bit in_serve = 1'b0;
   logic [DW-1:0] img_m [DEPTH];
   logic [CW-1:0] frozen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tot_cnt++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else begin
         pass_cnt++;
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (in_serve) exp_cycles++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_serve = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic enter_serve();
      load_done = 1'b1;
      step();
      load_done = 1'b0;
      in_serve = 1'b1;
      exp_cycles = 0;
   endtask

   task automatic finish_run();
      eng_if.finish = 1'b1;
      step();
      eng_if.finish = 1'b0;
      eng_if.lbp_valid = 1'b0;
      in_serve = 1'b0;
   endtask

   // load_done rides on the last write so the same-cycle case is exercised.
   task automatic load_image(input bit rnd);
      for (int a = 0; a < DEPTH; a++) begin
         img_m[a] = rnd ? DW'($urandom) : a[7:0];
         load_valid = 1'b1;
         load_addr  = AW'(a);
         load_data  = img_m[a];
         load_done  = (a == DEPTH - 1);
         if (a == 10 && !rnd) begin
            eng_if.gray_req  = 1'b1;
            eng_if.gray_addr = AW'(10);
            #1;
            chk("load_gray_data", 32'(eng_if.gray_data), 32'h0);
            chk("load_gray_ready", 32'(eng_if.gray_ready), 32'h0);
            eng_if.gray_req = 1'b0;
         end
         step();
      end
      load_valid = 1'b0;
      load_done  = 1'b0;
      in_serve   = 1'b1;
      exp_cycles = 0;
   endtask

   task automatic gray_read(input int addr, output logic [DW-1:0] val);
      eng_if.gray_req  = 1'b1;
      eng_if.gray_addr = AW'(addr);
      #1;
      val = eng_if.gray_data;
   endtask

   task automatic lbp_write(input int addr, input logic [DW-1:0] data);
      eng_if.lbp_valid = 1'b1;
      eng_if.lbp_addr  = AW'(addr);
      eng_if.lbp_data  = data;
      step();
   endtask

   function automatic logic [7:0] lbp_gold(input int r, input int c);
      logic [7:0] code;
      int b;
      code = '0;
      b = 0;
      for (int k = 0; k < 9; k++) begin
         if (k != 4) begin
            code[b] = img_m[(r + k/3 - 1)*IMG_W + c + k%3 - 1] >= img_m[r*IMG_W + c];
            b++;
         end
      end
      return code;
   endfunction

   // Plays the engine for one pixel: nine same-cycle reads, then one result write.
   task automatic run_pixel(input int r, input int c);
      logic [DW-1:0] nb [9];
      logic [7:0] code;
      int b;
      for (int k = 0; k < 9; k++) begin
         gray_read((r + k/3 - 1)*IMG_W + c + k%3 - 1, nb[k]);
         step();
      end
      eng_if.gray_req = 1'b0;
      code = '0;
      b = 0;
      for (int k = 0; k < 9; k++) begin
         if (k != 4) begin
            code[b] = nb[k] >= nb[4];
            b++;
         end
      end
      lbp_write(r*IMG_W + c, code);
      eng_if.lbp_valid = 1'b0;
   endtask

   int pix_r [6] = '{1, 1, 126, 126, 64, 10};
   int pix_c [6] = '{1, 126, 1, 126, 64, 100};

   initial begin
      logic [DW-1:0] v;
      reset = 1'b1;
      load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0; rd_addr = '0;
      eng_if.gray_req = 1'b0; eng_if.gray_addr = '0; eng_if.lbp_valid = 1'b0;
      eng_if.lbp_addr = '0; eng_if.lbp_data = '0; eng_if.finish = 1'b0;
      do_reset();
      chk("rst_gray_ready", 32'(eng_if.gray_ready), 32'h0);
      chk("rst_gray_data", 32'(eng_if.gray_data), 32'h0);
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_border_err", 32'(border_err), 32'h0);
      chk("rst_cycles", cycles, 32'h0);

      load_image(1'b0);
      chk("serve_gray_ready", 32'(eng_if.gray_ready), 32'h1);
      gray_read('h0081, v);
      chk("gray_0081", 32'(v), 32'h81);
      gray_read(DEPTH - 1, v);
      chk("gray_last_same_cycle_load", 32'(v), 32'hFF);
      eng_if.gray_req = 1'b0;
      eng_if.gray_addr = AW'(5);
      #1;
      chk("gray_req_low", 32'(eng_if.gray_data), 32'h0);
      step();

      lbp_write(129, 8'h11);
      lbp_write(129, 8'h5A);
      eng_if.lbp_valid = 1'b0;
      step();
      chk("interior_no_border", 32'(border_err), 32'h0);
      eng_if.lbp_valid = 1'b1;
      eng_if.lbp_addr = AW'(130);
      eng_if.lbp_data = 8'h33;
      finish_run();
      chk("done_set", 32'(done), 32'h1);
      chk("done_gray_ready", 32'(eng_if.gray_ready), 32'h0);
      chk("cycles_count", cycles, 32'(exp_cycles));

      frozen = cycles;
      lbp_write(129, 8'hEE);
      eng_if.lbp_valid = 1'b0;
      load_valid = 1'b1; load_addr = AW'('h81); load_data = 8'h00;
      step();
      load_valid = 1'b0;
      gray_read('h0081, v);
      chk("done_gray_data", 32'(v), 32'h0);
      eng_if.gray_req = 1'b0;
      chk("cycles_frozen", cycles, frozen);
      rd_addr = AW'(129);
      step();
      chk("rd_129_last_wins", 32'(rd_data), 32'h5A);
      rd_addr = AW'(130);
      step();
      chk("rd_130_finish_write", 32'(rd_data), 32'h33);

      do_reset();
      chk("reset_done_clear", 32'(done), 32'h0);
      chk("reset_cycles_clear", cycles, 32'h0);
      eng_if.finish = 1'b1;
      step();
      eng_if.finish = 1'b0;
      chk("finish_in_load_ignored", 32'(done), 32'h0);
      enter_serve();
      gray_read('h0081, v);
      chk("img_frozen_after_done", 32'(v), 32'h81);
      eng_if.gray_req = 1'b0;
      lbp_write(127, 8'h01);
      eng_if.lbp_valid = 1'b0;
      chk("border_col127", 32'(border_err), 32'h1);
      step();
      chk("border_sticky", 32'(border_err), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_gray_ready", 32'(eng_if.gray_ready), 32'h0);
      chk("async_rst_cycles", cycles, 32'h0);
      chk("async_rst_border", 32'(border_err), 32'h0);
      in_serve = 1'b0;
      step();
      reset = 1'b0;
      enter_serve();
      lbp_write(16256, 8'h02);
      eng_if.lbp_valid = 1'b0;
      chk("border_row127", 32'(border_err), 32'h1);

      do_reset();
      load_image(1'b1);
      for (int p = 0; p < 6; p++) run_pixel(pix_r[p], pix_c[p]);
      finish_run();
      chk("run_done", 32'(done), 32'h1);
      chk("run_border_err", 32'(border_err), 32'h0);
      chk("run_cycles", cycles, 32'(exp_cycles));
      for (int p = 0; p < 6; p++) begin
         rd_addr = AW'(pix_r[p]*IMG_W + pix_c[p]);
         step();
         chk($sformatf("lbp_r%0d_c%0d", pix_r[p], pix_c[p]), 32'(rd_data), 32'(lbp_gold(pix_r[p], pix_c[p])));
      end

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
